// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    LOAD_ADDR,
    LOAD_DATA,
    WRITE,
    WAIT_CHK,
    DONE
  } state_t;

  localparam int unsigned RAM_BYTES_DEF = 16;

  // Idle level of the active-low MAR/RAM control strobes.
  localparam logic CTL_IDLE = 1'b1;

  // Idle level of the host byte strobe.
  localparam logic STROBE_IDLE = 1'b0;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for the asynchronous host strobe, with a one-cycle
// rising-edge pulse taken after the second flop.
module strobe_sync
  import loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= {3{STROBE_IDLE}};
    end else begin
      sh <= {sh[1:0], strobe};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/program_loader.sv
// Writes host-supplied bytes into RAM at consecutive addresses while the CPU
// is held. Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned RAM_BYTES = RAM_BYTES_DEF,
  parameter int unsigned ADDR_W    = $clog2(RAM_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              programming,
  input  logic              strobe,
  input  logic [7:0]        ui_in,
  output logic              ready,
  output logic              done_load,
  output logic              cpu_hold,
  output logic              bus_en,
  output logic [7:0]        bus_out,
  output logic              nLma,
  output logic              nLmd,
  output logic              nLr,
  output logic [ADDR_W-1:0] load_addr,
  output logic              overrun,
  output logic              chk_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t     state, state_nx;
  logic       edge_p;
  logic [7:0] byte_q;
  logic       entering;

  strobe_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (strobe),
    .rise   (edge_p)
  );

  assign entering = (state == IDLE) && programming;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (programming) state_nx = WAIT_BYTE;
      WAIT_BYTE: if (edge_p) state_nx = LOAD_ADDR;
      LOAD_ADDR: state_nx = LOAD_DATA;
      LOAD_DATA: state_nx = WRITE;
      WRITE: begin
        if (load_addr == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = WAIT_CHK;
`else
          state_nx = DONE;
`endif
        end else begin
          state_nx = WAIT_BYTE;
        end
      end
      WAIT_CHK:  if (edge_p) state_nx = DONE;
      DONE:      state_nx = DONE;
      default:   state_nx = IDLE;
    endcase
    // Abort overrides every transition, including a same-cycle strobe edge.
    if (!programming) state_nx = IDLE;
  end

  always_comb begin
    ready     = (state == WAIT_BYTE) || (state == WAIT_CHK);
    done_load = (state == DONE);
    cpu_hold  = (state != IDLE);
    bus_en    = (state == LOAD_ADDR) || (state == LOAD_DATA);
    nLma      = CTL_IDLE;
    nLmd      = CTL_IDLE;
    nLr       = CTL_IDLE;
    bus_out   = '0;
    unique case (state)
      LOAD_ADDR: begin
        nLma    = ~CTL_IDLE;
        bus_out = 8'(load_addr);
      end
      LOAD_DATA: begin
        nLmd    = ~CTL_IDLE;
        bus_out = byte_q;
      end
      WRITE:     nLr = ~CTL_IDLE;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_q    <= '0;
      load_addr <= '0;
      overrun   <= 1'b0;
    end else if (entering) begin
      load_addr <= '0;
      overrun   <= 1'b0;
    end else begin
      if (edge_p && (state inside {LOAD_ADDR, LOAD_DATA, WRITE, DONE}))
        overrun <= 1'b1;
      if ((state == WAIT_BYTE) && edge_p && programming)
        byte_q <= ui_in;
      if ((state == WRITE) && programming && (load_addr != LAST_ADDR))
        load_addr <= load_addr + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       chk_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (entering) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (edge_p && programming) begin
      if (state == WAIT_BYTE) sum_q <= sum_q + ui_in;
      if (state == WAIT_CHK)  chk_err_q <= ((sum_q + ui_in) != 8'h00);
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven load, multi-cycle corner
// sequences, and randomized loads checked against an expected-RAM model.
module tb_program_loader;

  localparam int unsigned RB = 16;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst_n;
  logic          programming;
  logic          strobe;
  logic [7:0]    ui_in;
  logic          ready;
  logic          done_load;
  logic          cpu_hold;
  logic          bus_en;
  logic [7:0]    bus_out;
  logic          nLma;
  logic          nLmd;
  logic          nLr;
  logic [AW-1:0] load_addr;
  logic          overrun;
  logic          chk_err;

  program_loader #(.RAM_BYTES(RB), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .programming (programming),
    .strobe      (strobe),
    .ui_in       (ui_in),
    .ready       (ready),
    .done_load   (done_load),
    .cpu_hold    (cpu_hold),
    .bus_en      (bus_en),
    .bus_out     (bus_out),
    .nLma        (nLma),
    .nLmd        (nLmd),
    .nLr         (nLr),
    .load_addr   (load_addr),
    .overrun     (overrun),
    .chk_err     (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // External MAR/MDR/RAM as seen on the shared bus, plus protocol watchers.
  logic [7:0]    ram     [RB];
  logic [7:0]    exp_ram [RB];
  logic [AW-1:0] mar;
  logic [7:0]    mdr;
  int            writes    = 0;
  int            proto_bad = 0;
  int            hold_bad  = 0;
  bit            hold_watch = 1'b0;

  always @(negedge clk) begin
    if (!({nLma, nLmd, nLr} inside {3'b111, 3'b011, 3'b101, 3'b110})) proto_bad++;
    if (bus_en !== (!nLma || !nLmd)) proto_bad++;
    if (hold_watch && cpu_hold !== 1'b1) hold_bad++;
    if (nLma === 1'b0) mar = bus_out[AW-1:0];
    if (nLmd === 1'b0) mdr = bus_out;
    if (nLr === 1'b0) begin
      ram[mar] = mdr;
      writes++;
    end
  end

  task automatic enter();
    programming = 1'b1;
    @(negedge clk);
    check("enter_overrun_clear", overrun, 0);
  endtask

  task automatic leave();
    programming = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One full byte handshake; checks every phase of the per-byte sequence.
  task automatic send_byte(input logic [7:0] b, input int addr, input bit extra, input bit abort_w);
    int n;
    @(negedge clk);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ready_before", ready, 1);
    ui_in  = b;
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    strobe = 1'b0;
    n = 0;
    while (ready !== 1'b0 && n < 6) begin @(negedge clk); n++; end
    check("la_nLma", nLma, 0);
    check("la_bus_en", bus_en, 1);
    check("la_bus_out", bus_out, addr);
    check("la_load_addr", load_addr, addr);
    if (extra) strobe = 1'b1;
    @(negedge clk);
    check("ld_nLmd", nLmd, 0);
    check("ld_bus_out", bus_out, b);
    @(negedge clk);
    check("wr_nLr", nLr, 0);
    check("wr_bus_en", bus_en, 0);
    if (extra) strobe = 1'b0;
    exp_ram[addr] = b;
    if (abort_w) begin
      programming = 1'b0;
      @(negedge clk);
      check("abort_hold", cpu_hold, 0);
      check("abort_nLr", nLr, 1);
      check("abort_ready", ready, 0);
      return;
    end
    @(negedge clk);
    if (addr == RB - 1) begin
`ifdef LOADER_CHECKSUM_EN
      check("last_ready_chk", ready, 1);
      check("last_done_chk", done_load, 0);
`else
      check("last_done", done_load, 1);
      check("last_ready", ready, 0);
`endif
    end else begin
      check("next_ready", ready, 1);
      check("next_addr", load_addr, addr + 1);
    end
    if (extra) check("overrun_set", overrun, 1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic send_chk(input logic [7:0] b, input logic exp_err);
    int n;
    int w0;
    w0 = writes;
    @(negedge clk);
    check("chk_ready", ready, 1);
    ui_in  = b;
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    strobe = 1'b0;
    n = 0;
    while (done_load !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    check("chk_done", done_load, 1);
    check("chk_err", chk_err, exp_err);
    check("chk_no_write", writes, w0);
  endtask
`endif

  task automatic check_ram(input string name);
    for (int i = 0; i < RB; i++) check(name, ram[i], exp_ram[i]);
  endtask

  typedef struct {
    logic [7:0] data;
    int         addr;
  } vec_t;

  vec_t tbl [RB];

  initial begin
    int   n;
    int   w0;
    logic [7:0] sum;
    logic [7:0] b;

    for (int i = 0; i < RB; i++) begin
      tbl[i].data = 8'h10 + 8'(i);
      tbl[i].addr = i;
      ram[i]      = 8'h00;
      exp_ram[i]  = 8'h00;
    end

    rst_n = 1'b0; programming = 1'b0; strobe = 1'b0; ui_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_done", done_load, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_bus", {bus_en, bus_out}, 0);
    check("rst_ctl", {nLma, nLmd, nLr}, 3'b111);
    check("rst_flags", {load_addr, overrun, chk_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full table load 0x10..0x1F.
    enter();
    hold_watch = 1'b1;
    sum = 8'h00;
    for (int i = 0; i < RB; i++) begin
      send_byte(tbl[i].data, tbl[i].addr, 1'b0, 1'b0);
      sum = sum + tbl[i].data;
    end
`ifdef LOADER_CHECKSUM_EN
    send_chk(8'h00 - sum, 1'b0);
`endif
    hold_watch = 1'b0;
    check("hold_throughout", hold_bad, 0);
    for (int i = 0; i < RB; i++) check("tbl_ram", ram[i], tbl[i].data);

    // Strobe in DONE is ignored but flagged.
    w0 = writes;
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk); @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("done_no_write", writes, w0);
    check("done_overrun", overrun, 1);
    check("done_stays", done_load, 1);
    programming = 1'b0;
    @(negedge clk);
    check("done_falls", done_load, 0);
    check("done_hold_falls", cpu_hold, 0);
    @(negedge clk);

    // Extra strobe during byte 2 is dropped.
    enter();
    w0 = writes;
    send_byte(8'h21, 0, 1'b0, 1'b0);
    send_byte(8'h22, 1, 1'b1, 1'b0);
    send_byte(8'h23, 2, 1'b0, 1'b0);
    check("ovr_writes", writes - w0, 3);
    check_ram("ovr_ram");
    leave();

    // Abort during WRITE of byte 5, then restart at address 0.
    enter();
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), i, 1'b0, 1'b0);
    send_byte(8'h34, 4, 1'b0, 1'b1);
    @(negedge clk);
    enter();
    send_byte(8'hAA, 0, 1'b0, 1'b0);
    check_ram("abort_ram");
    leave();

    // Reset asserted during LOAD_DATA.
    enter();
    @(negedge clk);
    ui_in  = 8'h55;
    strobe = 1'b1;
    @(negedge clk); @(negedge clk);
    strobe = 1'b0;
    n = 0;
    while (nLmd !== 1'b0 && n < 8) begin @(negedge clk); n++; end
    check("reach_load_data", nLmd, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_nLmd", nLmd, 1);
    check("mid_rst_bus_en", bus_en, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_state", {ready, done_load, cpu_hold, bus_out, nLma, nLr, load_addr}, {3'b000, 8'h00, 2'b11, 4'h0});
    programming = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_ram("mid_rst_ram");

    // Randomized loads of random length.
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, RB));
      enter();
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        sum = sum + b;
        send_byte(b, k, 1'b0, 1'b0);
      end
`ifdef LOADER_CHECKSUM_EN
      if (n == RB) send_chk(8'h00 - sum, 1'b0);
`endif
      @(negedge clk);
      check("rand_done", done_load, (n == RB) ? 1 : 0);
      leave();
      check_ram("rand_ram");
    end

`ifdef LOADER_CHECKSUM_EN
    for (int r = 0; r < 2; r++) begin
      enter();
      w0 = writes;
      for (int i = 0; i < RB; i++) send_byte(8'h01, i, 1'b0, 1'b0);
      send_chk((r == 0) ? 8'hF0 : 8'hF1, (r == 0) ? 1'b0 : 1'b1);
      check("chk_writes", writes - w0, RB);
      check_ram("chk_ram");
      leave();
    end
`endif

    check("protocol", proto_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
